// File: rtl/parallel_receiver_pkg.sv
// Shared definitions for the parallel valid/ready link (receiver and transmitter sides).
package parallel_receiver_pkg;

  localparam int unsigned LINK_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE           = 2'b00,
    CAPTURE        = 2'b01,
    WAIT_VALID_LOW = 2'b10
  } link_state_t;

endpackage

// File: rtl/parallel_receiver_cdc_sync.sv
// Multi-flop synchroniser for a single asynchronous level signal.
module cdc_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/parallel_receiver_rx_fifo.sv
// Synchronous receive FIFO with registered read data; pointers carry an extra wrap bit.
module rx_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              rd_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_ok = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/parallel_receiver.sv
// Receive end of the 4-phase valid/ready parallel link, buffering words in rx_fifo.
// Optional frame counter port enabled by defining RX_FRAME_CNT_EN.
module parallel_receiver
  import parallel_receiver_pkg::*;
#(
  parameter int unsigned DATA_W      = LINK_DATA_W,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
`ifdef RX_FRAME_CNT_EN
  ,
  parameter int unsigned CNT_W       = 16
`endif
) (
  input  logic              clk_rx,
  input  logic              rst_rx,
  input  logic [DATA_W-1:0] parallel_data_in,
  input  logic              parallel_valid_in,
  output logic              parallel_ready_out,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              fifo_empty,
  output logic              fifo_full
`ifdef RX_FRAME_CNT_EN
  ,
  output logic [CNT_W-1:0]  frame_count
`endif
);

  link_state_t       state;
  logic [DATA_W-1:0] cap_q;
  logic              valid_sync;
  logic              wr;

  cdc_sync #(.STAGES(SYNC_STAGES)) u_valid_sync (
    .clk (clk_rx),
    .rst (rst_rx),
    .d   (parallel_valid_in),
    .q   (valid_sync)
  );

  // Write is gated by full so a stalled frame lands on the first edge space appears.
  assign wr = (state == CAPTURE) && !fifo_full;

  rx_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk_rx),
    .rst     (rst_rx),
    .wr_en   (wr),
    .wr_data (cap_q),
    .rd_en   (rd_en),
    .rd_data (data_out),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_ff @(posedge clk_rx or posedge rst_rx) begin
    if (rst_rx) begin
      state              <= IDLE;
      cap_q              <= '0;
      parallel_ready_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          parallel_ready_out <= 1'b0;
          if (valid_sync) begin
            cap_q <= parallel_data_in;
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (!fifo_full) begin
            parallel_ready_out <= 1'b1;
            state              <= WAIT_VALID_LOW;
          end
        end
        WAIT_VALID_LOW: begin
          if (!valid_sync) begin
            parallel_ready_out <= 1'b0;
            state              <= IDLE;
          end
        end
        default: begin
          parallel_ready_out <= 1'b0;
          state              <= IDLE;
        end
      endcase
    end
  end

`ifdef RX_FRAME_CNT_EN
  always_ff @(posedge clk_rx or posedge rst_rx) begin
    if (rst_rx)  frame_count <= '0;
    else if (wr) frame_count <= frame_count + 1'b1;
  end
`endif

endmodule
